vga_mem_arbiter: RTL and testbench

//  Schedules the single-port frame memory between VGA scanout and one pixel-writer client.

---
 rtl/vga_mem_arbiter_if.sv | 27 ++
 rtl/vga_mem_arbiter.sv | 65 ++++++
 tb/tb_vga_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_mem_arbiter_if.sv
// vga_mem_arbiter_if: raster position, pixel-writer and frame-memory signals of the VGA memory arbiter.
// Master is the surrounding system; slave is the arbiter.
interface vga_mem_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic [15:0]       HCount;
  logic [15:0]       VCount;
  logic              iWrReq;
  logic [ADDR_W-1:0] iWrAddr;
  logic [DATA_W-1:0] iWrData;
  logic              oWrReady;
  logic [ADDR_W-1:0] oMemAddr;
  logic              oMemRe;
  logic              oMemWe;
  logic [DATA_W-1:0] oMemWdata;
  logic [DATA_W-1:0] iMemRdata;
  logic [DATA_W-1:0] oPixel;
  modport master (
    output HCount, VCount, iWrReq, iWrAddr, iWrData, iMemRdata,
    input  oWrReady, oMemAddr, oMemRe, oMemWe, oMemWdata, oPixel
  );
  modport slave (
    input  HCount, VCount, iWrReq, iWrAddr, iWrData, iMemRdata,
    output oWrReady, oMemAddr, oMemRe, oMemWe, oMemWdata, oPixel
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares a single-port frame memory between scanout (3-slot lookahead prefetch)
// and one pixel writer that gets every slot scanout leaves free.
module vga_mem_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int SCALE_SH = 0,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 12
) (
  input logic               iClk,
  input logic               iRst_n,
  vga_mem_arbiter_if.slave  bus
);
  logic [15:0]       fx_raw, fx, fy_raw, fy;
  logic              wrap, la_act, wr_go;
  logic [ADDR_W-1:0] la_addr;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              re_q, re_d, we_q, we_d, rv_q, rv_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, pix_q, pix_d;
  always_comb begin
    fx_raw  = bus.HCount + 16'd3;
    wrap    = fx_raw >= 16'(H_TOTAL);
    fx      = wrap ? fx_raw - 16'(H_TOTAL) : fx_raw;
    fy_raw  = wrap ? bus.VCount + 16'd1 : bus.VCount;
    fy      = (fy_raw >= 16'(V_TOTAL)) ? 16'd0 : fy_raw;
    la_act  = (bus.HCount < 16'(H_TOTAL)) && (bus.VCount < 16'(V_TOTAL)) &&
              (fx < 16'(H_ACTIVE)) && (fy < 16'(V_ACTIVE));
    la_addr = ADDR_W'(fy >> SCALE_SH) * ADDR_W'(H_ACTIVE >> SCALE_SH) + ADDR_W'(fx >> SCALE_SH);
  end
  // Scanout wins every slot it needs; the writer only gets slots where the lookahead is idle.
  always_comb begin
    wr_go   = bus.iWrReq && !la_act;
    re_d    = la_act;
    we_d    = wr_go;
    addr_d  = la_act ? la_addr : wr_go ? bus.iWrAddr : addr_q;
    wdata_d = wr_go ? bus.iWrData : wdata_q;
    rv_d    = re_q;
    pix_d   = rv_q ? bus.iMemRdata : '0;
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      addr_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      rv_q    <= 1'b0;
      wdata_q <= '0;
      pix_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      re_q    <= re_d;
      we_q    <= we_d;
      rv_q    <= rv_d;
      wdata_q <= wdata_d;
      pix_q   <= pix_d;
    end
  end
  assign bus.oWrReady  = iRst_n && !la_act;
  assign bus.oMemAddr  = addr_q;
  assign bus.oMemRe    = re_q;
  assign bus.oMemWe    = we_q;
  assign bus.oMemWdata = wdata_q;
  assign bus.oPixel    = pix_q;
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: directed checks of the VGA memory arbiter at scale 0 (instance a) and scale 2 (instance b).
module tb_vga_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hc = '0, vc = '0;
  logic        wreq = 1'b0, wreq_b = 1'b0;
  logic [18:0] waddr = '0;
  logic [11:0] wdata = '0;
  logic [11:0] rd_a = '0, rd_b = '0;
  int vec = 0, errs = 0;
  vga_mem_arbiter_if bus_a ();
  vga_mem_arbiter_if bus_b ();
  vga_mem_arbiter #(.SCALE_SH(0)) dut_a (.iClk(clk), .iRst_n(rst_n), .bus(bus_a));
  vga_mem_arbiter #(.SCALE_SH(2)) dut_b (.iClk(clk), .iRst_n(rst_n), .bus(bus_b));
  assign bus_a.HCount = hc;
  assign bus_a.VCount = vc;
  assign bus_a.iWrReq = wreq;
  assign bus_a.iWrAddr = waddr;
  assign bus_a.iWrData = wdata;
  assign bus_a.iMemRdata = rd_a;
  assign bus_b.HCount = hc;
  assign bus_b.VCount = vc;
  assign bus_b.iWrReq = wreq_b;
  assign bus_b.iWrAddr = 19'h7777;
  assign bus_b.iWrData = 12'h777;
  assign bus_b.iMemRdata = rd_b;
  always #5 clk = ~clk;
  // Frame memory contents as a fixed function of address; read data arrives one cycle after the address.
  function automatic logic [11:0] memf(input logic [18:0] a);
    return (a == 19'd640) ? 12'hABC : (a[11:0] ^ 12'h5A5);
  endfunction
  always @(posedge clk) begin
    rd_a <= memf(bus_a.oMemAddr);
    rd_b <= memf(bus_b.oMemAddr);
  end
  task automatic set_pos(input int h, input int v);
    @(posedge clk);
    #1;
    hc = 16'(h);
    vc = 16'(v);
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
    if (hc == 16'd799) begin
      hc = 16'd0;
      vc = (vc == 16'd524) ? 16'd0 : vc + 16'd1;
    end else hc = hc + 16'd1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    wreq = 1'b1;
    wreq_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      hc = 16'($urandom_range(0, 799));
      vc = 16'($urandom_range(0, 524));
      @(negedge clk);
      vec++;
      if ({bus_a.oMemAddr, bus_a.oMemRe, bus_a.oMemWe, bus_a.oMemWdata, bus_a.oPixel, bus_a.oWrReady} !== '0) begin
        errs++;
        $display("FAIL reset_a: addr=%h re=%b we=%b wd=%h pix=%h rdy=%b, all required 0", bus_a.oMemAddr,
                 bus_a.oMemRe, bus_a.oMemWe, bus_a.oMemWdata, bus_a.oPixel, bus_a.oWrReady);
      end
      vec++;
      if ({bus_b.oMemRe, bus_b.oMemWe, bus_b.oPixel, bus_b.oWrReady} !== '0) begin
        errs++;
        $display("FAIL reset_b: re=%b we=%b pix=%h rdy=%b, all required 0", bus_b.oMemRe, bus_b.oMemWe,
                 bus_b.oPixel, bus_b.oWrReady);
      end
    end
    wreq = 1'b0;
    wreq_b = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic test_line_prefetch();
    set_pos(797, 0);
    nxt();
    @(negedge clk);
    vec++;
    if (bus_a.oMemRe !== 1'b1 || bus_a.oMemAddr !== 19'd640 || bus_a.oMemWe !== 1'b0) begin
      errs++;
      $display("FAIL prefetch_read: re=%b we=%b addr=%0d, required re=1 we=0 addr=640", bus_a.oMemRe,
               bus_a.oMemWe, bus_a.oMemAddr);
    end
    nxt();
    nxt();
    @(negedge clk);
    vec++;
    if (bus_a.oPixel !== 12'hABC) begin
      errs++;
      $display("FAIL prefetch_pixel: oPixel=%h at (0,1), required abc", bus_a.oPixel);
    end
  endtask
  task automatic test_frame_wrap();
    set_pos(797, 524);
    nxt();
    @(negedge clk);
    vec++;
    if (bus_a.oMemRe !== 1'b1 || bus_a.oMemAddr !== 19'd0) begin
      errs++;
      $display("FAIL wrap_read: re=%b addr=%0d, required re=1 addr=0", bus_a.oMemRe, bus_a.oMemAddr);
    end
    nxt();
    nxt();
    @(negedge clk);
    vec++;
    if (bus_a.oPixel !== 12'h5A5) begin
      errs++;
      $display("FAIL wrap_pixel00: oPixel=%h, required 5a5", bus_a.oPixel);
    end
    set_pos(636, 479);
    nxt();
    @(negedge clk);
    vec++;
    if (bus_a.oMemRe !== 1'b1 || bus_a.oMemAddr !== 19'd307199) begin
      errs++;
      $display("FAIL last_read: re=%b addr=%0d, required re=1 addr=307199", bus_a.oMemRe, bus_a.oMemAddr);
    end
    nxt();
    @(negedge clk);
    vec++;
    if (bus_a.oMemRe !== 1'b0) begin
      errs++;
      $display("FAIL past_edge_read: re=%b at (638,479), required 0", bus_a.oMemRe);
    end
    nxt();
    @(negedge clk);
    vec++;
    if (bus_a.oPixel !== 12'hA5A) begin
      errs++;
      $display("FAIL last_pixel: oPixel=%h at (639,479), required a5a", bus_a.oPixel);
    end
    nxt();
    @(negedge clk);
    vec++;
    if (bus_a.oPixel !== 12'h000) begin
      errs++;
      $display("FAIL blank_pixel: oPixel=%h at (640,479), required 000", bus_a.oPixel);
    end
  endtask
  task automatic test_active_write();
    set_pos(100, 10);
    wreq = 1'b1;
    waddr = 19'h12345;
    wdata = 12'h3C3;
    for (int h = 100; h < 637; h++) begin
      @(negedge clk);
      vec++;
      if (bus_a.oWrReady !== 1'b0 || bus_a.oMemWe !== 1'b0) begin
        errs++;
        $display("FAIL active_block: rdy=%b we=%b at (%0d,10), required 0 0", bus_a.oWrReady, bus_a.oMemWe, h);
      end
      nxt();
    end
    @(negedge clk);
    vec++;
    if (bus_a.oWrReady !== 1'b1) begin
      errs++;
      $display("FAIL ready_637: rdy=%b, required 1", bus_a.oWrReady);
    end
    nxt();
    wreq = 1'b0;
    @(negedge clk);
    vec++;
    if (bus_a.oMemWe !== 1'b1 || bus_a.oMemRe !== 1'b0 || bus_a.oMemAddr !== 19'h12345 || bus_a.oMemWdata !== 12'h3C3) begin
      errs++;
      $display("FAIL write_638: we=%b re=%b addr=%h wd=%h, required we=1 re=0 addr=12345 wd=3c3", bus_a.oMemWe,
               bus_a.oMemRe, bus_a.oMemAddr, bus_a.oMemWdata);
    end
    nxt();
    @(negedge clk);
    vec++;
    if (bus_a.oMemWe !== 1'b0 || bus_a.oMemRe !== 1'b0 || bus_a.oMemAddr !== 19'h12345 || bus_a.oMemWdata !== 12'h3C3) begin
      errs++;
      $display("FAIL idle_hold: we=%b re=%b addr=%h wd=%h, required we=0 re=0 addr=12345 wd=3c3", bus_a.oMemWe,
               bus_a.oMemRe, bus_a.oMemAddr, bus_a.oMemWdata);
    end
    set_pos(797, 10);
    wreq = 1'b1;
    @(negedge clk);
    vec++;
    if (bus_a.oWrReady !== 1'b0) begin
      errs++;
      $display("FAIL ready_797: rdy=%b, required 0", bus_a.oWrReady);
    end
    wreq = 1'b0;
  endtask
  task automatic test_back_to_back();
    set_pos(0, 490);
    wreq = 1'b1;
    for (int i = 0; i < 51; i++) begin
      if (i == 50) wreq = 1'b0;
      waddr = 19'(1000 + i);
      wdata = 12'(i * 37);
      @(negedge clk);
      vec++;
      if (i < 50 && bus_a.oWrReady !== 1'b1) begin
        errs++;
        $display("FAIL vblank_ready: rdy=%b at write %0d, required 1", bus_a.oWrReady, i);
      end
      if (i > 0) begin
        vec++;
        if (bus_a.oMemWe !== 1'b1 || bus_a.oMemRe !== 1'b0 || bus_a.oMemAddr !== 19'(999 + i) ||
            bus_a.oMemWdata !== 12'((i - 1) * 37)) begin
          errs++;
          $display("FAIL vblank_write %0d: we=%b re=%b addr=%0d wd=%h, required we=1 re=0 addr=%0d wd=%h", i - 1,
                   bus_a.oMemWe, bus_a.oMemRe, bus_a.oMemAddr, bus_a.oMemWdata, 999 + i, 12'((i - 1) * 37));
        end
      end
      nxt();
    end
    @(negedge clk);
    vec++;
    if (bus_a.oMemWe !== 1'b0) begin
      errs++;
      $display("FAIL vblank_stop: we=%b after last write, required 0", bus_a.oMemWe);
    end
  endtask
  task automatic test_scale2();
    set_pos(1, 0);
    nxt();
    for (int x = 2; x < 8; x++) begin
      @(negedge clk);
      if (x <= 5) begin
        vec++;
        if (bus_b.oMemRe !== 1'b1 || bus_b.oMemAddr !== 19'd1) begin
          errs++;
          $display("FAIL s2_read x=%0d: re=%b addr=%0d, required re=1 addr=1", x + 2, bus_b.oMemRe, bus_b.oMemAddr);
        end
      end
      if (x >= 4) begin
        vec++;
        if (bus_b.oPixel !== memf(19'd1)) begin
          errs++;
          $display("FAIL s2_pixel x=%0d: oPixel=%h, required %h", x, bus_b.oPixel, memf(19'd1));
        end
      end
      nxt();
    end
    set_pos(200, 5);
    wreq_b = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    vec++;
    if (bus_b.oPixel !== 12'h000 || bus_b.oMemRe !== 1'b0 || bus_b.oMemWe !== 1'b0) begin
      errs++;
      $display("FAIL s2_async_reset: pix=%h re=%b we=%b, required 0", bus_b.oPixel, bus_b.oMemRe, bus_b.oMemWe);
    end
    nxt();
    nxt();
    rst_n = 1'b1;
    for (int x = 202; x < 213; x++) begin
      @(negedge clk);
      vec++;
      if (bus_b.oMemWe !== 1'b0) begin
        errs++;
        $display("FAIL s2_no_write x=%0d: we=%b, required 0", x, bus_b.oMemWe);
      end
      vec++;
      if (bus_b.oPixel !== ((x < 205) ? 12'h000 : memf(19'(160 + x / 4)))) begin
        errs++;
        $display("FAIL s2_release_pixel x=%0d: oPixel=%h, required %h", x, bus_b.oPixel,
                 (x < 205) ? 12'h000 : memf(19'(160 + x / 4)));
      end
      nxt();
    end
    wreq_b = 1'b0;
  endtask
  initial begin
    test_reset();
    test_line_prefetch();
    test_frame_wrap();
    test_active_write();
    test_back_to_back();
    test_scale2();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
